// File: rtl/bus_sequencer_if.sv
// Request handshake and bus-control signals between a requester and bus_sequencer.
interface bus_sequencer_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned N_REGS = 2 ** SEL_W;

   logic              req;
   logic [SEL_W-1:0]  src_a;
   logic [SEL_W-1:0]  src_b;
   logic              use_b;
   logic [SEL_W-1:0]  dst;
   logic              wr_en;
   logic              stall;
   logic              ready;
   logic [N_REGS-1:0] enable1;
   logic [N_REGS-1:0] enable2;
   logic [N_REGS-1:0] load;
   logic              done;
   logic [7:0]        xfer_count;

   modport master (
      output req, src_a, src_b, use_b, dst, wr_en, stall,
      input  ready, enable1, enable2, load, done, xfer_count
   );

   modport slave (
      input  req, src_a, src_b, use_b, dst, wr_en, stall,
      output ready, enable1, enable2, load, done, xfer_count
   );
endinterface

// File: rtl/bus_sequencer.sv
// Sequences one register-to-register transfer over two tri-state buses:
// drive sources, strobe the destination load, then release both buses.
module bus_sequencer #(
   parameter int unsigned SEL_W = 3
) (
   input logic           clk,
   input logic           rst,
   bus_sequencer_if.slave bus
);
   localparam int unsigned N_REGS = 2 ** SEL_W;

   typedef enum logic [1:0] {IDLE, DRIVE, WRITE, RELEASE} state_t;

   state_t            state;
   logic [SEL_W-1:0]  dst_q;
   logic              wr_en_q;
   logic [N_REGS-1:0] enable1_q;
   logic [N_REGS-1:0] enable2_q;
   logic [N_REGS-1:0] load_q;
   logic              ready_q;
   logic              done_q;
   logic [7:0]        count_q;

   function automatic logic [N_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
      logic [N_REGS-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

   // Source selections are captured directly as one-hot enables at acceptance,
   // so the enable registers double as the latched src_a/src_b/use_b fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dst_q     <= '0;
         wr_en_q   <= 1'b0;
         enable1_q <= '0;
         enable2_q <= '0;
         load_q    <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.req) begin
                  dst_q     <= bus.dst;
                  wr_en_q   <= bus.wr_en;
                  enable1_q <= onehot(bus.src_a);
                  enable2_q <= bus.use_b ? onehot(bus.src_b) : '0;
                  ready_q   <= 1'b0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               if (!bus.stall) begin
                  load_q <= wr_en_q ? onehot(dst_q) : '0;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               enable1_q <= '0;
               enable2_q <= '0;
               load_q    <= '0;
               done_q    <= 1'b1;
               count_q   <= count_q + 8'd1;
               state     <= RELEASE;
            end
            RELEASE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.enable1    = enable1_q;
   assign bus.enable2    = enable2_q;
   assign bus.load       = load_q;
   assign bus.done       = done_q;
   assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-timeline reference model.
module tb_bus_sequencer;
   localparam int unsigned SEL_W = 3;
   localparam int NMAX = 3000;

   logic clk = 1'b0;
   logic rst;

   bus_sequencer_if #(.SEL_W(SEL_W)) bus ();

   bus_sequencer #(.SEL_W(SEL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // stimulus sampled at edge j, and expected outputs for the cycle after edge j
   bit          s_req[NMAX], s_ub[NMAX], s_wr[NMAX], s_stall[NMAX], s_rst[NMAX];
   int unsigned s_a[NMAX], s_b[NMAX], s_d[NMAX];
   int unsigned x_e1[NMAX], x_e2[NMAX], x_ld[NMAX], x_cnt[NMAX];
   bit          x_done[NMAX], x_rdy[NMAX];

   int n = 0;
   int n_chk = 0;
   int n_pass = 0;
   int m34, m35, m36, m37, m38, m39;
   int done_seen = 0;
   int unsigned load_seen = 0;

   task automatic chk(input string tag, input int cyc, input int unsigned got, input int unsigned want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
   endtask

   task automatic put(input bit r, input int unsigned a, input int unsigned b, input bit ub,
                      input int unsigned d, input bit wr, input bit st, input bit rs);
      s_req[n] = r; s_a[n] = a; s_b[n] = b; s_ub[n] = ub;
      s_d[n] = d; s_wr[n] = wr; s_stall[n] = st; s_rst[n] = rs;
      n++;
   endtask

   task automatic put_idle(input int cycles);
      for (int i = 0; i < cycles; i++) put(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic put_reset(input int cycles);
      for (int i = 0; i < cycles; i++) put(1, 7, 7, 1, 7, 1, 1, 1);
   endtask

   // Each accepted transaction occupies a fixed timeline: drive from acceptance up to
   // the first unstalled edge, one write cycle, one release cycle, then idle again.
   task automatic build_model();
      bit          have = 0;
      bit          idle_prev = 1;
      int          k = 0;
      int          e = 0;
      int unsigned a = 0, b = 0, d = 0;
      bit          ub = 0, wr = 0;
      int unsigned cnt = 0;
      for (int j = 0; j < n; j++) begin
         x_e1[j] = 0; x_e2[j] = 0; x_ld[j] = 0; x_done[j] = 0;
         if (s_rst[j]) begin
            have = 0; cnt = 0; idle_prev = 1;
            x_rdy[j] = 1; x_cnt[j] = 0;
            continue;
         end
         if (idle_prev && s_req[j]) begin
            have = 1; k = j;
            a = s_a[j]; b = s_b[j]; ub = s_ub[j]; d = s_d[j]; wr = s_wr[j];
            e = j + 1;
            while (e < n && s_stall[e]) e++;
         end
         if (have && j >= k && j <= e) begin
            x_e1[j] = 1 << a;
            x_e2[j] = ub ? (1 << b) : 0;
            if (j == e && wr) x_ld[j] = 1 << d;
         end
         if (have && j == e + 1) begin
            x_done[j] = 1;
            cnt = (cnt + 1) % 256;
         end
         x_rdy[j] = !have || j >= e + 2;
         x_cnt[j] = cnt;
         idle_prev = x_rdy[j];
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.req = 0; bus.src_a = '0; bus.src_b = '0; bus.use_b = 0;
      bus.dst = '0; bus.wr_en = 0; bus.stall = 0;

      put_reset(3);
      m34 = n; put(1, 2, 5, 1, 7, 1, 0, 0); put_idle(6);
      m35 = n; put(1, 2, 5, 1, 7, 1, 0, 0);
      for (int i = 0; i < 3; i++) put(0, 0, 0, 0, 0, 0, 1, 0);
      put_idle(8);
      m39 = n; put(1, 1, 6, 1, 3, 1, 0, 0); put(1, 4, 2, 0, 5, 0, 0, 0); put_idle(6);
      put_reset(2);
      m36 = n;
      for (int i = 0; i < 12; i++)
         put(1, $urandom_range(7), $urandom_range(7), 0, $urandom_range(7), $urandom_range(1), 0, 0);
      put_idle(6);
      put_reset(2);
      m37 = n; put(1, 3, 4, 1, 6, 1, 0, 0); put_idle(1); put_reset(1); put_idle(4);
      put_reset(1);
      m38 = n;
      for (int i = 0; i < 1024; i++)
         put(1, $urandom_range(7), $urandom_range(7), $urandom_range(1), $urandom_range(7), 0, 0, 0);
      put_idle(3);
      while (n < NMAX) begin
         put($urandom_range(1), $urandom_range(7), $urandom_range(7), $urandom_range(1),
             $urandom_range(7), $urandom_range(1), ($urandom_range(9) < 3),
             ($urandom_range(49) == 0));
      end

      build_model();

      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         rst = s_rst[j]; bus.req = s_req[j]; bus.src_a = 3'(s_a[j]); bus.src_b = 3'(s_b[j]);
         bus.use_b = s_ub[j]; bus.dst = 3'(s_d[j]); bus.wr_en = s_wr[j]; bus.stall = s_stall[j];
         @(posedge clk);
         #1;
         chk("enable1", j, bus.enable1, x_e1[j]);
         chk("enable2", j, bus.enable2, x_e2[j]);
         chk("load", j, bus.load, x_ld[j]);
         chk("done", j, bus.done, x_done[j]);
         chk("ready", j, bus.ready, x_rdy[j]);
         chk("xfer_count", j, bus.xfer_count, x_cnt[j]);
         chk("enable1_onehot", j, $countones(bus.enable1) <= 1, 1);
         chk("load_onehot", j, $countones(bus.load) <= 1, 1);

         if (j == m34)     begin chk("d34_e1", j, bus.enable1, 'h04); chk("d34_e2", j, bus.enable2, 'h20); chk("d34_ld0", j, bus.load, 0); end
         if (j == m34 + 1) begin chk("d34_e1w", j, bus.enable1, 'h04); chk("d34_ld", j, bus.load, 'h80); end
         if (j == m34 + 2) begin chk("d34_done", j, bus.done, 1); chk("d34_cnt", j, bus.xfer_count, 1); chk("d34_rel", j, bus.enable1, 0); end
         if (j == m34 + 3) chk("d34_ready", j, bus.ready, 1);
         if (j == m35 + 3) chk("d35_ld_stalled", j, bus.load, 0);
         if (j == m35 + 4) chk("d35_ld", j, bus.load, 'h80);
         if (j == m35 + 5) chk("d35_done", j, bus.done, 1);
         if (j == m39 + 1) begin chk("d39_e1", j, bus.enable1, 'h02); chk("d39_e2", j, bus.enable2, 'h40); chk("d39_ld", j, bus.load, 'h08); end
         if (j >= m36 && j < m36 + 18) chk("d36_e2", j, bus.enable2, 0);
         if (j == m36 + 17) chk("d36_cnt", j, bus.xfer_count, 3);
         if (j == m37 + 2) begin
            chk("d37_e1", j, bus.enable1, 0); chk("d37_ld", j, bus.load, 0);
            chk("d37_done", j, bus.done, 0); chk("d37_cnt", j, bus.xfer_count, 0);
            chk("d37_ready", j, bus.ready, 1);
         end
         if (j >= m38 && j < m38 + 1027) begin
            if (bus.done) done_seen++;
            load_seen = load_seen | 32'(bus.load);
         end
         if (j == m38 + 1026) begin
            chk("d38_dones", j, done_seen, 256);
            chk("d38_load", j, load_seen, 0);
            chk("d38_wrap", j, bus.xfer_count, 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, the register-select width.
REQ-002 The block SHALL have localparam N_REGS = 2**SEL_W, the number of register_2oe-style registers controlled.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  transfer request; qualified by ready.
REQ-006 src_a  input  SEL_W  register driven onto bus 1.
REQ-007 src_b  input  SEL_W  register driven onto bus 2.
REQ-008 use_b  input  1  1 = bus 2 also driven; 0 = bus 1 only.
REQ-009 dst  input  SEL_W  register loaded at end of transfer.
REQ-010 wr_en  input  1  1 = load dst; 0 = read-only transfer.
REQ-011 stall  input  1  extends the DRIVE phase while high.
REQ-012 ready  output  1  high only in IDLE; request accepted when req && ready at a clock edge.
REQ-013 enable1  output  N_REGS  one-hot or zero bus-1 output enables.
REQ-014 enable2  output  N_REGS  one-hot or zero bus-2 output enables.
REQ-015 load  output  N_REGS  one-hot or zero register load strobes.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 xfer_count  output  8  count of completed transfers.

Function
REQ-018 States SHALL be IDLE, DRIVE, WRITE, RELEASE; all outputs registered or decoded from registered state/fields only (no input-to-output combinational path).
REQ-019 On req && ready at the rising edge: latch src_a, src_b, use_b, dst, wr_en; go IDLE->DRIVE; req without ready SHALL be ignored (no latch, no state change).
REQ-020 DRIVE: enable1[src_a]=1; enable2[src_b]=use_b; load=0; stay in DRIVE while stall=1, else go to WRITE.
REQ-021 WRITE (exactly one cycle): enables held as in DRIVE; load[dst]=wr_en; next RELEASE.
REQ-022 RELEASE (exactly one cycle): enable1=enable2=load=0; done=1; xfer_count += 1; next IDLE.
REQ-023 Unstalled latency: accept edge k -> DRIVE cycle k+1, WRITE k+2, RELEASE/done k+3, ready again k+4; req held high gives one transfer per 4 cycles.
REQ-024 At no time SHALL more than one bit of enable1, of enable2, or of load be high.
REQ-025 All enables SHALL be 0 for at least one cycle (RELEASE) between consecutive transfers (break-before-make on both buses).
REQ-026 src_a==src_b with use_b=1 is legal: the same register drives both buses.
REQ-027 dst equal to src_a or src_b is legal: load and enable are asserted together in WRITE.
REQ-028 Input changes on src_a/src_b/dst/use_b/wr_en after acceptance SHALL NOT affect the in-flight transfer.
REQ-029 stall outside DRIVE SHALL be ignored.
REQ-030 xfer_count SHALL wrap 255->0; a read-only transfer (wr_en=0) SHALL still count and pulse done.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE from any state, including mid-transfer, with no done pulse and no count increment.
REQ-032 After reset: enable1=0, enable2=0, load=0, done=0, xfer_count=0, ready=1, latched fields=0.
REQ-033 req is ignored at any edge where rst=1; rst has priority over stall and req.

Verification
REQ-034 Reset, then req=1, src_a=2, src_b=5, use_b=1, dst=7, wr_en=1 for one cycle -> enable1=0x04, enable2=0x20 in cycles k+1 and k+2; load=0x80 in k+2 only; done=1 in k+3; xfer_count=1; ready=1 at k+4.
REQ-035 Same request with stall high for 3 cycles after accept -> DRIVE lasts 4 cycles, load=0x80 only in the following cycle, done 6 cycles after accept.
REQ-036 req held high for 12 cycles, use_b=0 -> exactly 3 transfers, enable2 always 0, enable1 zero in every RELEASE cycle, xfer_count=3.
REQ-037 rst asserted during WRITE -> next cycle all enables/load=0, done=0, xfer_count unchanged, ready=1.
REQ-038 Issue 256 read-only transfers (wr_en=0) -> load never nonzero, 256 done pulses, xfer_count wraps to 0.
REQ-039 Change src_a/dst on the cycle after accept -> enables/load still reflect the originally latched values.
